// File: rtl/data_mem_ws.sv
// data_mem_ws: wait-state data memory with Req/Ready handshake, sized loads/stores and faults.
// Optional macro DMEM_PARITY_EN keeps one even-parity bit per byte and flags mismatches on loads.
module data_mem_ws #(
    parameter int DEPTH_LOG2   = 5,
    parameter int WAIT_CYCLES  = 2,
    parameter int INIT_SQUARES = 1
) (
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic        Req,
    input  logic        Wr,
    input  logic [1:0]  Size,
    input  logic        Unsigned,
    input  logic [31:0] Addr,
    input  logic [31:0] WData,
    output logic        Ready,
    output logic [31:0] RData,
    output logic        Fault,
    output logic        Busy,
    output logic        ParityErr
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [3:0] WC = 4'(WAIT_CYCLES);

    typedef logic [DEPTH-1:0][31:0] mem_t;
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    function automatic mem_t init_words();
        mem_t m;
        m = 'x;
        for (int i = 0; i < DEPTH; i++)
            if (INIT_SQUARES != 0) m[i] = 32'(i * i);
        return m;
    endfunction

    mem_t ram = init_words();

    state_t                state;
    logic [3:0]            cnt;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic [1:0]            lane_q;
    logic [1:0]            size_q;
    logic                  wr_q;
    logic                  uns_q;
    logic [31:0]           wd_q;

    logic                  fault_in;
    logic                  do_access;
    logic [31:0]           word;
    logic [7:0]            b;
    logic [15:0]           h;
    logic [31:0]           ld;
    logic [31:0]           wrep;
    logic [3:0]            mask;
    logic                  par_bad;

    assign fault_in  = Size == 2'b11 || (Size == 2'b01 && Addr[0]) ||
                       (Size == 2'b10 && Addr[1:0] != 2'b00) ||
                       (Addr >> (DEPTH_LOG2 + 2)) != 32'd0;
    assign do_access = state == S_WAIT && cnt == 4'd0;

    // Lane selection, load extension and store replication for the latched request.
    always_comb begin
        word = ram[idx_q];
        b    = word[8*lane_q +: 8];
        h    = lane_q[1] ? word[31:16] : word[15:0];
        ld   = size_q == 2'b00 ? {{24{~uns_q & b[7]}}, b}
             : size_q == 2'b01 ? {{16{~uns_q & h[15]}}, h} : word;
        mask = size_q == 2'b00 ? 4'b0001 << lane_q
             : size_q == 2'b01 ? (lane_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wrep = size_q == 2'b00 ? {4{wd_q[7:0]}}
             : size_q == 2'b01 ? {2{wd_q[15:0]}} : wd_q;
    end

`ifdef DMEM_PARITY_EN
    typedef logic [DEPTH-1:0][3:0] par_t;

    function automatic par_t init_par();
        mem_t m;
        par_t p;
        m = init_words();
        for (int i = 0; i < DEPTH; i++)
            for (int k = 0; k < 4; k++)
                p[i][k] = ^m[i][8*k +: 8];
        return p;
    endfunction

    par_t       par = init_par();
    logic [3:0] calc;

    assign calc    = {^word[31:24], ^word[23:16], ^word[15:8], ^word[7:0]};
    assign par_bad = |((par[idx_q] ^ calc) & mask);
`else
    assign par_bad = 1'b0;
`endif

    // Store at the access edge: only the enabled byte lanes (and their parity) change.
    always_ff @(posedge Clock) begin
        if (Reset_n && do_access && wr_q)
            for (int k = 0; k < 4; k++)
                if (mask[k]) begin
                    ram[idx_q][8*k +: 8] <= wrep[8*k +: 8];
`ifdef DMEM_PARITY_EN
                    par[idx_q][k] <= ^wrep[8*k +: 8];
`endif
                end
    end

    // Handshake FSM with registered outputs: accept in IDLE, count waits, pulse Ready in DONE.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            Ready     <= 1'b0;
            RData     <= 32'd0;
            Fault     <= 1'b0;
            Busy      <= 1'b0;
            ParityErr <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (Req) begin
                    idx_q     <= Addr[DEPTH_LOG2+1:2];
                    lane_q    <= Addr[1:0];
                    size_q    <= Size;
                    wr_q      <= Wr;
                    uns_q     <= Unsigned;
                    wd_q      <= WData;
                    cnt       <= WC;
                    Busy      <= 1'b1;
                    state     <= fault_in ? S_DONE : S_WAIT;
                    Ready     <= fault_in;
                    Fault     <= fault_in;
                    RData     <= 32'd0;
                    ParityErr <= 1'b0;
                end
                S_WAIT: if (cnt != 4'd0) begin
                    cnt <= cnt - 4'd1;
                end else begin
                    state     <= S_DONE;
                    Ready     <= 1'b1;
                    Fault     <= 1'b0;
                    RData     <= wr_q ? 32'd0 : ld;
                    ParityErr <= !wr_q && par_bad;
                end
                default: begin
                    state     <= S_IDLE;
                    Busy      <= 1'b0;
                    Ready     <= 1'b0;
                    RData     <= 32'd0;
                    Fault     <= 1'b0;
                    ParityErr <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_ws.sv
// tb_data_mem_ws: scoreboard bench for data_mem_ws with a byte-array reference model.
module tb_data_mem_ws;
    localparam int W = 2;

    logic        Clock = 1'b0;
    logic        Reset_n = 1'b0;
    logic        Req = 1'b0;
    logic        Wr = 1'b0;
    logic [1:0]  Size = 2'b00;
    logic        Unsigned = 1'b0;
    logic [31:0] Addr = 32'd0;
    logic [31:0] WData = 32'd0;
    logic        Ready;
    logic [31:0] RData;
    logic        Fault;
    logic        Busy;
    logic        ParityErr;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        logic        perr;
        int          due;
    } exp_t;

    exp_t       q[$];
    exp_t       e_mon;
    logic [7:0] mem [128];
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    bit         mon_on = 1'b0;
    int         flip_word = -1;

    data_mem_ws #(.DEPTH_LOG2(5), .WAIT_CYCLES(W), .INIT_SQUARES(1)) dut (
        .Clock(Clock), .Reset_n(Reset_n), .Req(Req), .Wr(Wr), .Size(Size),
        .Unsigned(Unsigned), .Addr(Addr), .WData(WData), .Ready(Ready),
        .RData(RData), .Fault(Fault), .Busy(Busy), .ParityErr(ParityErr)
    );

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: byte-addressed memory, spec fault rules, arithmetic extension.
    function automatic exp_t model(input logic wr, input logic [1:0] size, input logic uns,
                                   input logic [31:0] addr, input logic [31:0] wdata);
        exp_t        e;
        int          n;
        logic [31:0] v;
        e = '{32'd0, 1'b0, 1'b0, 0};
        n = size == 2'd0 ? 1 : size == 2'd1 ? 2 : 4;
        e.fault = size == 2'd3 || addr % n != 0 || addr >= 128;
        if (e.fault) return e;
        v = 32'd0;
        for (int k = 0; k < n; k++)
            if (wr) mem[addr + k] = wdata[8*k +: 8];
            else v = v | (32'(mem[addr + k]) << (8 * k));
        if (!wr) begin
            if (n < 4 && !uns && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
            e.rdata = v;
            e.perr  = int'(addr / 4) == flip_word;
        end
        return e;
    endfunction

    task automatic send(input logic wr, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
        exp_t e;
        @(negedge Clock);
        Req = 1'b1; Wr = wr; Size = size; Unsigned = uns; Addr = addr; WData = wdata;
        e = model(wr, size, uns, addr, wdata);
        e.due = cyc + (e.fault ? 1 : W + 2);
        q.push_back(e);
        @(negedge Clock);
        Req = 1'b0;
    endtask

    task automatic finish_wait();
        int n;
        n = 0;
        while ((q.size() != 0 || Busy) && n < 40) begin
            @(negedge Clock);
            n++;
        end
        if (q.size() != 0 || Busy) begin
            checks++;
            failures++;
            $display("FAIL timeout: pending %0d busy %b", q.size(), Busy);
            q.delete();
        end
    endtask

    // Monitor: pops the oldest expectation on every Ready pulse; outputs must be quiet otherwise.
    always @(negedge Clock) begin
        if (mon_on) begin
            if (Ready) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_ready: rdata %h fault %b", RData, Fault);
                end else begin
                    e_mon = q.pop_front();
                    check("rdata", RData, e_mon.rdata);
                    check("fault", {31'd0, Fault}, {31'd0, e_mon.fault});
                    check("parity_err", {31'd0, ParityErr}, {31'd0, e_mon.perr});
                    check("ready_cycle", cyc, e_mon.due);
                end
            end else begin
                check("quiet_rdata", RData, 32'd0);
                check("quiet_flags", {30'd0, Fault, ParityErr}, 32'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        logic [1:0]  s;
        int          c;
        int          busy_low;
        for (int i = 0; i < 32; i++)
            for (int k = 0; k < 4; k++) begin
                a = 32'(i * i);
                mem[4*i + k] = a[8*k +: 8];
            end

        repeat (3) @(negedge Clock);
        check("reset_ready", {31'd0, Ready}, 32'd0);
        check("reset_rdata", RData, 32'd0);
        check("reset_fault", {31'd0, Fault}, 32'd0);
        check("reset_busy", {31'd0, Busy}, 32'd0);
        check("reset_perr", {31'd0, ParityErr}, 32'd0);
        Reset_n = 1'b1;
        mon_on  = 1'b1;

        send(1'b0, 2'd2, 1'b0, 32'h0C, 32'd0);
        finish_wait();

        send(1'b1, 2'd0, 1'b0, 32'h11, 32'h80);
        finish_wait();
        send(1'b0, 2'd0, 1'b0, 32'h11, 32'd0);
        finish_wait();
        send(1'b0, 2'd0, 1'b1, 32'h11, 32'd0);
        finish_wait();
        send(1'b0, 2'd2, 1'b0, 32'h10, 32'd0);
        finish_wait();

        send(1'b0, 2'd1, 1'b0, 32'h03, 32'd0);
        finish_wait();
        send(1'b1, 2'd2, 1'b0, 32'h80, 32'h1234_5678);
        finish_wait();
        send(1'b0, 2'd2, 1'b0, 32'h00, 32'd0);
        finish_wait();

        @(negedge Clock);
        Req = 1'b1; Wr = 1'b1; Size = 2'd2; Unsigned = 1'b0; Addr = 32'h08; WData = 32'hDEAD_BEEF;
        @(negedge Clock);
        Req = 1'b0;
        check("busy_in_wait", {31'd0, Busy}, 32'd1);
        Reset_n = 1'b0;
        mon_on  = 1'b0;
        @(negedge Clock);
        check("abort_ready", {31'd0, Ready}, 32'd0);
        check("abort_rdata", RData, 32'd0);
        check("abort_fault", {31'd0, Fault}, 32'd0);
        check("abort_busy", {31'd0, Busy}, 32'd0);
        check("abort_perr", {31'd0, ParityErr}, 32'd0);
        Reset_n = 1'b1;
        mon_on  = 1'b1;
        send(1'b0, 2'd2, 1'b0, 32'h08, 32'd0);
        finish_wait();

        @(negedge Clock);
        c = cyc;
        Req = 1'b1; Wr = 1'b0; Size = 2'd2; Unsigned = 1'b0; Addr = 32'h0C;
        for (int k = 0; k < 4; k++) begin
            exp_t e;
            e = model(1'b0, 2'd2, 1'b0, 32'h0C, 32'd0);
            e.due = c + 5 * k + W + 2;
            q.push_back(e);
        end
        busy_low = 0;
        repeat (20) begin
            @(negedge Clock);
            if (!Busy) busy_low++;
        end
        Req = 1'b0;
        check("busy_low_cycles", 32'(busy_low), 32'd4);
        finish_wait();

        for (int i = 0; i < 80; i++) begin
            s = $urandom_range(0, 9) == 0 ? 2'd3 : 2'($urandom_range(0, 2));
            a = 32'($urandom_range(0, 127));
            if ($urandom_range(0, 4) != 0)
                a = a & (s == 2'd1 ? 32'hFFFF_FFFE : s == 2'd2 ? 32'hFFFF_FFFC : 32'hFFFF_FFFF);
            if ($urandom_range(0, 11) == 0) a = $urandom | 32'h80;
            send(1'($urandom_range(0, 1)), s, 1'($urandom_range(0, 1)), a, $urandom);
            finish_wait();
        end

`ifdef DMEM_PARITY_EN
        dut.par[3][0] = ~dut.par[3][0];
        flip_word = 3;
        send(1'b0, 2'd2, 1'b0, 32'h0C, 32'd0);
        finish_wait();
        dut.par[3][0] = ~dut.par[3][0];
        flip_word = -1;
`endif

        repeat (2) @(negedge Clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
